// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage that sits directly in front of the instruction queue. It holds
//   the fetch PC and issues word requests to the instruction memory. In-order
//   responses go into a small skid buffer, and from there {address, instruction}
//   entries are pushed into the queue. A redirect flushes the queue, drops every
//   response that is still in flight, and restarts fetch at the new PC.
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   redirect, redirectAddr   restart request and its target (bits [1:0] ignored)
//   iReqValid/iReqReady      request handshake toward memory, iReqAddr = pc
//   iRspValid/iRspData       in-order responses, never back-pressured
//   iRspError                access fault flag attached to a response
//   queueFull                the instruction queue cannot take an entry
//   push, instrOut, iAddrOut queue write strobe with instruction bits [31:2]
//                            and fetch address bits [XLEN-4:2]
//   queueFlush               equals redirect
//   fetchError               high while the FSM is in ERR (this is the state)
//
// Handshake: a request transfers on a cycle where iReqValid and iReqReady are
// both high. The memory tolerates iReqValid being withdrawn before a transfer.
// There is exactly one response per transferred request, in order, and a
// response cannot be stalled.
module instr_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              SKID_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectAddr,
    output logic            iReqValid,
    input  logic            iReqReady,
    output logic [XLEN-1:0] iReqAddr,
    input  logic            iRspValid,
    input  logic [31:0]     iRspData,
    input  logic            iRspError,
    input  logic            queueFull,
    output logic            push,
    output logic [29:0]     instrOut,
    output logic [XLEN-6:0] iAddrOut,
    output logic            queueFlush,
    output logic            fetchError
);

    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = XLEN - 5;
    localparam int EW = AW + 30;

    typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;       // fetch address of the next non-discarded response
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   discard_q;
    logic [CW-1:0]   skid_cnt_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]   skid_mem [SKID_DEPTH];

    logic            req_valid;
    logic            accept;
    logic            rsp_live;
    logic            skid_wr;
    logic            err_hit;
    logic [CW:0]     occupancy;
    logic [CW-1:0]   out_next;
    logic [EW-1:0]   head;

    // In-flight requests plus buffered words can never exceed the skid size,
    // so every response always finds a free slot.
    assign occupancy = {1'b0, outstanding_q} + {1'b0, skid_cnt_q};
    assign rsp_live  = iRspValid & (discard_q == '0) & ~redirect & (state_q == RUN);
    assign skid_wr   = rsp_live & ~iRspError;
    assign err_hit   = rsp_live & iRspError;

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        case (state_q)
            RUN: begin
                req_valid = ~redirect & (occupancy < (CW+1)'(SKID_DEPTH));
                if (err_hit) state_d = ERR;
            end
            ERR: begin
                if (redirect) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign iReqValid  = req_valid & ~reset;
    assign iReqAddr   = pc_q;
    assign accept     = iReqValid & iReqReady;
    assign out_next   = outstanding_q + CW'(accept) - CW'(iRspValid);

    assign push       = (skid_cnt_q != '0) & ~queueFull & ~redirect & ~reset;
    assign head       = skid_mem[rd_ptr_q];
    assign iAddrOut   = push ? head[EW-1:30] : '0;
    assign instrOut   = push ? head[29:0]    : '0;
    assign queueFlush = redirect;
    assign fetchError = (state_q == ERR) & ~reset;

    always_ff @(posedge clock) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            skid_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            outstanding_q <= out_next;
            if (redirect) begin
                pc_q       <= {redirectAddr[XLEN-1:2], 2'b00};
                rsp_pc_q   <= {redirectAddr[XLEN-1:2], 2'b00};
                // A response arriving in the redirect cycle is dropped here,
                // so it is not counted among those still to discard.
                discard_q  <= outstanding_q - CW'(iRspValid);
                skid_cnt_q <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
            end else begin
                if (accept) pc_q <= pc_q + XLEN'(4);
                if (iRspValid) begin
                    if (discard_q != '0) begin
                        discard_q <= discard_q - CW'(1);
                    end else if (err_hit) begin
                        // Everything still in flight after this cycle is stale.
                        discard_q <= out_next;
                    end else if (skid_wr) begin
                        rsp_pc_q <= rsp_pc_q + XLEN'(4);
                    end
                end
                if (skid_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (push)    rd_ptr_q <= rd_ptr_q + PW'(1);
                skid_cnt_q <= skid_cnt_q + CW'(skid_wr) - CW'(push);
            end
        end
    end

    // Skid data needs no reset: the count and pointers define what is valid.
    always_ff @(posedge clock) begin
        if (skid_wr & ~reset) begin
            skid_mem[wr_ptr_q] <= {rsp_pc_q[XLEN-4:2], iRspData[31:2]};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{iRspData[1:0], redirectAddr[1:0],
                           rsp_pc_q[XLEN-1:XLEN-3], rsp_pc_q[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int W     = 57;  // {addr[28:2], instr[31:2]}

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset = 1'b1;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirectAddr = '0;
  logic            iReqValid;
  logic            iReqReady = 1'b0;
  logic [XLEN-1:0] iReqAddr;
  logic            iRspValid = 1'b0;
  logic [31:0]     iRspData = '0;
  logic            iRspError = 1'b0;
  logic            queueFull = 1'b0;
  logic            push;
  logic [29:0]     instrOut;
  logic [XLEN-6:0] iAddrOut;
  logic            queueFlush;
  logic            fetchError;

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .SKID_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirectAddr(redirectAddr),
    .iReqValid(iReqValid), .iReqReady(iReqReady), .iReqAddr(iReqAddr),
    .iRspValid(iRspValid), .iRspData(iRspData), .iRspError(iRspError),
    .queueFull(queueFull), .push(push), .instrOut(instrOut), .iAddrOut(iAddrOut),
    .queueFlush(queueFlush), .fetchError(fetchError)
  );

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
    bit          err;
  } req_t;

  req_t         memq[$];      // memory: accepted requests not yet answered
  logic [W-1:0] exp_q[$];     // words that must still be pushed, in order
  logic [31:0]  m_pc;
  bit           m_err;
  int           last_due;
  int           cyc;
  int           vectors;
  int           miscompares;

  int           g_lat_min, g_lat_max, g_err_pct;
  bit           g_err_en;
  logic [31:0]  g_err_addr;

  logic [31:0]  acc_log[$];
  logic [26:0]  push_log[$];
  int           push_cyc_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a * 32'h9E3779B1) ^ 32'h5A5A0000) | 32'h3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete();
    push_log.delete();
    push_cyc_log.delete();
  endtask

  // ---------------- driver + compare, one call per clock ----------------
  task automatic cycle(input bit rst, input bit redir, input logic [31:0] raddr,
                       input bit rdy, input bit qf);
    req_t         r;
    req_t         n;
    bit           rsp;
    bit           exp_rv;
    bit           exp_push;
    logic [31:0]  w;
    @(negedge clock);
    reset        = rst;
    redirect     = redir;
    redirectAddr = raddr;
    iReqReady    = rdy;
    queueFull    = qf;
    rsp          = !rst && memq.size() > 0 && memq[0].due <= cyc;
    iRspValid    = rsp;
    iRspData     = rsp ? mem_word(memq[0].addr) : $urandom;
    iRspError    = rsp ? memq[0].err : 1'b0;
    #1;
    exp_rv   = !rst && !m_err && !redir && (memq.size() + exp_q.size() < DEPTH);
    exp_push = !rst && !redir && !qf && exp_q.size() > 0;
    check("iReqValid", 64'(iReqValid), 64'(exp_rv));
    check("push", 64'(push), 64'(exp_push));
    check("queueFlush", 64'(queueFlush), 64'(redir));
    check("fetchError", 64'(fetchError), 64'(!rst && m_err));
    if (exp_rv && iReqValid) check("iReqAddr", 64'(iReqAddr), 64'(m_pc));
    if (exp_push && push) check("push_entry", 64'({iAddrOut, instrOut}), 64'(exp_q[0]));
    if (push) begin
      push_log.push_back(iAddrOut);
      push_cyc_log.push_back(cyc);
    end

    if (rst) begin
      memq.delete();
      exp_q.delete();
      m_pc     = 32'h0;
      m_err    = 1'b0;
      last_due = 0;
    end else begin
      if (rsp) r = memq.pop_front();
      if (redir) begin
        foreach (memq[i]) memq[i].stale = 1'b1;
        exp_q.delete();
        m_err = 1'b0;
        m_pc  = {raddr[31:2], 2'b00};
      end else begin
        if (exp_push) void'(exp_q.pop_front());
        if (exp_rv && rdy) begin
          n.addr  = m_pc;
          n.due   = cyc + $urandom_range(g_lat_min, g_lat_max);
          if (n.due <= last_due) n.due = last_due + 1;
          last_due = n.due;
          n.stale = 1'b0;
          n.err   = (g_err_en && m_pc == g_err_addr) ||
                    (g_err_pct > 0 && $urandom_range(0, 99) < g_err_pct);
          memq.push_back(n);
          acc_log.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        if (rsp && !r.stale) begin
          if (r.err) begin
            m_err = 1'b1;
            foreach (memq[i]) memq[i].stale = 1'b1;
          end else begin
            w = mem_word(r.addr);
            exp_q.push_back({r.addr[28:2], w[31:2]});
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    clear_logs();
  endtask

  task automatic run(input int n, input bit rdy, input bit qf);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, rdy, qf);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int t0;
    vectors = 0; miscompares = 0; cyc = 0;
    m_pc = 0; m_err = 0; last_due = 0;
    g_lat_min = 1; g_lat_max = 1; g_err_pct = 0; g_err_en = 0; g_err_addr = 0;

    // Streaming with 1-cycle memory
    do_reset();
    t0 = cyc;
    cycle(0, 0, 0, 1, 0);
    check("t1_first_valid", 64'(iReqValid), 64'd1);
    check("t1_first_addr", 64'(iReqAddr), 64'h0);
    run(12, 1, 0);
    check("t1_push_count_min", 64'(push_log.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) check("t1_order", 64'(push_log[i]), 64'(i));
    check("t1_latency", 64'(push_cyc_log[0] - t0), 64'd2);

    // Queue full: exactly DEPTH requests, then drain back to back
    do_reset();
    run(12, 1, 1);
    check("t2_accepts", 64'(acc_log.size()), 64'd4);
    check("t2_valid_low", 64'(iReqValid), 64'd0);
    clear_logs();
    run(4, 0, 0);
    check("t2_drain_count", 64'(push_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t2_drain_order", 64'(push_log[i]), 64'(i));
    check("t2_back_to_back", 64'(push_cyc_log[3] - push_cyc_log[0]), 64'd3);

    // Redirect with two requests in flight, latency 3
    do_reset();
    g_lat_min = 3; g_lat_max = 3;
    run(2, 1, 0);
    clear_logs();
    cycle(0, 1, 32'h100, 1, 0);
    check("t3_flush", 64'(queueFlush), 64'd1);
    run(12, 1, 0);
    check("t3_first_push", 64'(push_log[0]), 64'h40);

    // Redirect coincident with a response while the skid holds words
    do_reset();
    g_lat_min = 1; g_lat_max = 1;
    run(4, 1, 1);
    clear_logs();
    cycle(0, 1, 32'h40, 1, 0);
    check("t4_rsp_in_redirect", 64'(iRspValid), 64'd1);
    cycle(0, 0, 0, 1, 0);
    check("t4_skid_empty", 64'(push), 64'd0);
    run(10, 1, 0);
    check("t4_first_push", 64'(push_log[0]), 64'h10);

    // Access fault on the word at 0x8
    do_reset();
    g_lat_min = 2; g_lat_max = 2; g_err_en = 1; g_err_addr = 32'h8;
    run(8, 1, 1);
    check("t5_fetch_error", 64'(fetchError), 64'd1);
    check("t5_no_issue", 64'(iReqValid), 64'd0);
    run(6, 1, 0);
    check("t5_buffered_count", 64'(push_log.size()), 64'd2);
    check("t5_buffered_0", 64'(push_log[0]), 64'h0);
    check("t5_buffered_1", 64'(push_log[1]), 64'h1);
    g_err_en = 0;
    clear_logs();
    cycle(0, 1, 32'h200, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("t5_error_cleared", 64'(fetchError), 64'd0);
    run(10, 1, 0);
    check("t5_resume", 64'(push_log[0]), 64'h80);

    // PC wrap, then reset with a full skid
    do_reset();
    g_lat_min = 1; g_lat_max = 1;
    cycle(0, 1, 32'hFFFF_FFFF, 1, 0);
    run(3, 1, 0);
    check("t6_wrap_a", 64'(acc_log[0]), 64'hFFFF_FFFC);
    check("t6_wrap_b", 64'(acc_log[1]), 64'h0);
    run(10, 1, 1);
    check("t6_skid_full", 64'(exp_q.size()), 64'd4);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("t6_after_reset_valid", 64'(iReqValid), 64'd1);
    check("t6_after_reset_addr", 64'(iReqAddr), 64'h0);

    // Randomized traffic against the model
    g_lat_min = 1; g_lat_max = 4; g_err_pct = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 99) < 15) ra = 32'hFFFF_FFF0 | (ra & 32'hF);
      if ($urandom_range(0, 499) == 0)
        cycle(1, 0, 0, 1, 0);
      else
        cycle(0, $urandom_range(0, 24) == 0, ra,
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
